// File: rtl/reshape_out_framer.sv
// reshape_out_framer: frames the reshape output stream for the DMA S2MM channel.
//   Computes the layer's beat count from the output geometry and passes the
//   stream through a 2-entry registered buffer. It asserts M_Last on the final
//   beat and pulses Write_Complete once that beat has been accepted.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   Start                     one-cycle pulse: latch geometry, arm a transfer
//   Row/Col_Num_Out_REG       output feature-map rows / columns
//   Channel_Out_Num_REG       channel groups (one beat per group per pixel)
//   S_Data/S_Valid/S_Ready    upstream stream from the reshape output
//   M_Data/M_Valid/M_Ready    downstream stream to the DMA
//   M_Last                    final beat of the transfer
//   Busy                      transfer in progress
//   Write_Complete            one-cycle layer-done pulse
//   Beat_Total                latched beat count
module reshape_out_framer #(
    parameter int DATA_WIDTH            = 128,
    parameter int WIDTH_FEATURE_SIZE    = 11,
    parameter int WIDTH_CHANNEL_NUM_REG = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             Start,
    input  logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_Out_REG,
    input  logic [WIDTH_FEATURE_SIZE-1:0]    Col_Num_Out_REG,
    input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_Out_Num_REG,
    input  logic [DATA_WIDTH-1:0]            S_Data,
    input  logic                             S_Valid,
    output logic                             S_Ready,
    output logic [DATA_WIDTH-1:0]            M_Data,
    output logic                             M_Valid,
    input  logic                             M_Ready,
    output logic                             M_Last,
    output logic                             Busy,
    output logic                             Write_Complete,
    output logic [31:0]                      Beat_Total
);
    localparam int PW = 2 * WIDTH_FEATURE_SIZE;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CALC1 = 3'd1;
    localparam logic [2:0] CALC2 = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]                       state_q, state_d;
    logic [WIDTH_FEATURE_SIZE-1:0]    rows_q, cols_q;
    logic [WIDTH_CHANNEL_NUM_REG-1:0] grp_q;
    logic [PW-1:0]                    prod_q;
    logic [31:0]                      total_q, in_cnt_q, out_cnt_q, beats;
    logic [DATA_WIDTH-1:0]            d0_q, d1_q;
    logic [1:0]                       cnt_q;
    logic                             push, pop;

    assign beats          = 32'(prod_q) * 32'(grp_q);
    assign S_Ready        = (state_q == RUN) && (in_cnt_q < total_q) && (cnt_q < 2'd2);
    assign M_Valid        = cnt_q != 2'd0;
    assign M_Data         = d0_q;
    // out_cnt only moves on a handshake, so M_Last is stable while stalled
    assign M_Last         = M_Valid && (out_cnt_q == total_q - 32'd1);
    assign push           = S_Valid && S_Ready;
    assign pop            = M_Valid && M_Ready;
    assign Busy           = (state_q == CALC1) || (state_q == CALC2) || (state_q == RUN);
    assign Write_Complete = state_q == DONE;
    assign Beat_Total     = total_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = Start ? CALC1 : IDLE;
            CALC1:   state_d = CALC2;
            CALC2:   state_d = (beats == 32'd0) ? DONE : RUN;
            RUN:     state_d = (pop && M_Last) ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            grp_q     <= '0;
            prod_q    <= '0;
            total_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            d0_q      <= '0;
            d1_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && Start) begin
                rows_q    <= Row_Num_Out_REG;
                cols_q    <= Col_Num_Out_REG;
                grp_q     <= Channel_Out_Num_REG;
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                if (push) in_cnt_q <= in_cnt_q + 32'd1;
                if (pop) out_cnt_q <= out_cnt_q + 32'd1;
            end
            if (state_q == CALC1) prod_q <= PW'(rows_q) * PW'(cols_q);
            if (state_q == CALC2) total_q <= beats;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
            // d0 is always the head; a push lands in d0 when it will be the head
            if (pop && cnt_q == 2'd2) d0_q <= d1_q;
            else if (push && (cnt_q == 2'd0 || pop)) d0_q <= S_Data;
            else if (push) d1_q <= S_Data;
        end
    end
endmodule

// File: tb/tb_reshape_out_framer.sv
// tb_reshape_out_framer: directed scenario bench for reshape_out_framer.
module tb_reshape_out_framer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         Start = 1'b0;
    logic [10:0]  Row_Num_Out_REG = '0;
    logic [10:0]  Col_Num_Out_REG = '0;
    logic [9:0]   Channel_Out_Num_REG = '0;
    logic [127:0] S_Data = '0;
    logic         S_Valid = 1'b0;
    logic         S_Ready;
    logic [127:0] M_Data;
    logic         M_Valid;
    logic         M_Ready = 1'b0;
    logic         M_Last;
    logic         Busy;
    logic         Write_Complete;
    logic [31:0]  Beat_Total;

    int checks = 0;
    int errors = 0;
    int n_in, n_out, n_bad, n_last, last_idx, last_iter, n_wc, wc_iter;
    int n_unstable, sready_hi, sready_after, first_sready, busy0, hold_cnt;

    reshape_out_framer dut (
        .clk(clk), .rst(rst), .Start(Start),
        .Row_Num_Out_REG(Row_Num_Out_REG), .Col_Num_Out_REG(Col_Num_Out_REG),
        .Channel_Out_Num_REG(Channel_Out_Num_REG),
        .S_Data(S_Data), .S_Valid(S_Valid), .S_Ready(S_Ready),
        .M_Data(M_Data), .M_Valid(M_Valid), .M_Ready(M_Ready), .M_Last(M_Last),
        .Busy(Busy), .Write_Complete(Write_Complete), .Beat_Total(Beat_Total)
    );

    always #5 clk = ~clk;

    // Runs one transfer; iteration 0 is the cycle right after Start is sampled.
    // mr_mode: 0 = M_Ready always 1, 1 = random, 2 = hold low 10 cycles on M_Last.
    task automatic drive_xfer(input int r, input int c, input int g, input int mr_mode,
                              input int sv_rand, input int restart_at, input logic [127:0] base);
        int  exp_n;
        logic prev_stall, prev_s_hs, pl, s_hs, m_hs;
        logic [127:0] pd;
        exp_n = r * c * g;
        n_in = 0; n_out = 0; n_bad = 0; n_last = 0; last_idx = -1; last_iter = -1;
        n_wc = 0; wc_iter = -100; n_unstable = 0; sready_hi = 0; sready_after = 0;
        first_sready = -1; hold_cnt = 0;
        prev_stall = 0; prev_s_hs = 0; pl = 0; pd = '0;
        Row_Num_Out_REG = 11'(r); Col_Num_Out_REG = 11'(c); Channel_Out_Num_REG = 10'(g);
        Start = 1; S_Valid = 0; M_Ready = 0;
        @(posedge clk); #1;
        Start = 0;
        busy0 = Busy;
        for (int i = 0; i < 6000 && !(n_wc > 0 && i > wc_iter + 1); i++) begin
            if (S_Ready) sready_hi++;
            if (S_Ready && first_sready < 0) first_sready = i;
            if (S_Ready && n_in >= exp_n) sready_after++;
            if (Write_Complete) begin n_wc++; wc_iter = i; end
            if (prev_stall && (!M_Valid || M_Data !== pd || M_Last !== pl)) n_unstable++;
            if (!(S_Valid && !prev_s_hs)) S_Valid = (sv_rand != 0 && n_in < exp_n) ? 1'($urandom % 2) : 1'b1;
            S_Data = base + 128'(n_in);
            Start = (i == restart_at);
            if (i == restart_at) begin
                Row_Num_Out_REG = 11'd1; Col_Num_Out_REG = 11'd1; Channel_Out_Num_REG = 10'd1;
            end
            if (mr_mode == 1) M_Ready = 1'($urandom % 2);
            else if (mr_mode == 2 && M_Last && hold_cnt < 10) begin M_Ready = 0; hold_cnt++; end
            else M_Ready = 1;
            s_hs = S_Valid && S_Ready;
            m_hs = M_Valid && M_Ready;
            if (m_hs) begin
                if (M_Data !== base + 128'(n_out)) n_bad++;
                if (M_Last) begin n_last++; last_idx = n_out; last_iter = i; end
                n_out++;
            end
            if (s_hs) n_in++;
            prev_stall = M_Valid && !M_Ready;
            pd = M_Data; pl = M_Last; prev_s_hs = s_hs;
            @(posedge clk); #1;
        end
        Start = 0; S_Valid = 0; M_Ready = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (S_Ready !== 1'b0) begin errors++; $display("FAIL rst_sready got %b exp 0", S_Ready); end
        checks++; if (M_Valid !== 1'b0) begin errors++; $display("FAIL rst_mvalid got %b exp 0", M_Valid); end
        checks++; if (M_Last !== 1'b0) begin errors++; $display("FAIL rst_mlast got %b exp 0", M_Last); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", Busy); end
        checks++; if (Write_Complete !== 1'b0) begin errors++; $display("FAIL rst_wc got %b exp 0", Write_Complete); end
        checks++; if (Beat_Total !== 32'd0) begin errors++; $display("FAIL rst_total got %0d exp 0", Beat_Total); end
        checks++; if (M_Data !== 128'd0) begin errors++; $display("FAIL rst_mdata got %0h exp 0", M_Data); end
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        drive_xfer(2, 2, 1, 0, 0, -1, 128'd1);
        checks++; if (busy0 !== 1) begin errors++; $display("FAIL basic_busy_t1 got %0d exp 1", busy0); end
        checks++; if (first_sready !== 2) begin errors++; $display("FAIL basic_first_sready got %0d exp 2", first_sready); end
        checks++; if (n_out !== 4) begin errors++; $display("FAIL basic_nout got %0d exp 4", n_out); end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL basic_data got %0d bad exp 0", n_bad); end
        checks++; if (n_last !== 1 || last_idx !== 3) begin errors++; $display("FAIL basic_last got n=%0d idx=%0d exp n=1 idx=3", n_last, last_idx); end
        checks++; if (last_iter !== 6) begin errors++; $display("FAIL basic_throughput last at %0d exp 6", last_iter); end
        checks++; if (n_wc !== 1 || wc_iter - last_iter !== 1) begin errors++; $display("FAIL basic_wc got n=%0d delay=%0d exp n=1 delay=1", n_wc, wc_iter - last_iter); end
        checks++; if (Beat_Total !== 32'd4) begin errors++; $display("FAIL basic_total got %0d exp 4", Beat_Total); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b exp 0", Busy); end
    endtask

    task automatic test_random_676;
        drive_xfer(13, 13, 4, 1, 1, -1, 128'h1000);
        checks++; if (n_in !== 676) begin errors++; $display("FAIL rand_nin got %0d exp 676", n_in); end
        checks++; if (n_out !== 676) begin errors++; $display("FAIL rand_nout got %0d exp 676", n_out); end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL rand_order got %0d bad exp 0", n_bad); end
        checks++; if (n_last !== 1 || last_idx !== 675) begin errors++; $display("FAIL rand_last got n=%0d idx=%0d exp n=1 idx=675", n_last, last_idx); end
        checks++; if (sready_after !== 0) begin errors++; $display("FAIL rand_sready_after got %0d exp 0", sready_after); end
        checks++; if (n_unstable !== 0) begin errors++; $display("FAIL rand_stable got %0d exp 0", n_unstable); end
        checks++; if (Beat_Total !== 32'd676) begin errors++; $display("FAIL rand_total got %0d exp 676", Beat_Total); end
        checks++; if (n_wc !== 1) begin errors++; $display("FAIL rand_wc got %0d exp 1", n_wc); end
    endtask

    task automatic test_zero;
        drive_xfer(5, 0, 3, 0, 0, -1, 128'd0);
        checks++; if (n_out !== 0) begin errors++; $display("FAIL zero_nout got %0d exp 0", n_out); end
        checks++; if (sready_hi !== 0) begin errors++; $display("FAIL zero_sready got %0d exp 0", sready_hi); end
        checks++; if (n_last !== 0) begin errors++; $display("FAIL zero_last got %0d exp 0", n_last); end
        checks++; if (n_wc !== 1 || wc_iter !== 2) begin errors++; $display("FAIL zero_wc got n=%0d at=%0d exp n=1 at=2", n_wc, wc_iter); end
        checks++; if (Beat_Total !== 32'd0) begin errors++; $display("FAIL zero_total got %0d exp 0", Beat_Total); end
    endtask

    task automatic test_restart;
        drive_xfer(3, 3, 2, 0, 0, 5, 128'h200);
        checks++; if (n_out !== 18) begin errors++; $display("FAIL restart_nout got %0d exp 18", n_out); end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL restart_data got %0d bad exp 0", n_bad); end
        checks++; if (n_wc !== 1) begin errors++; $display("FAIL restart_wc got %0d exp 1", n_wc); end
        checks++; if (Beat_Total !== 32'd18) begin errors++; $display("FAIL restart_total got %0d exp 18", Beat_Total); end
    endtask

    task automatic test_reset_mid;
        int ni, no;
        ni = 0; no = 0;
        Row_Num_Out_REG = 11'd4; Col_Num_Out_REG = 11'd4; Channel_Out_Num_REG = 10'd1;
        Start = 1;
        @(posedge clk); #1;
        Start = 0;
        for (int i = 0; i < 40 && !(ni >= 5 && no >= 3); i++) begin
            S_Valid = 1; S_Data = 128'(ni + 50); M_Ready = (no < 3);
            if (S_Valid && S_Ready) ni++;
            if (M_Valid && M_Ready) no++;
            @(posedge clk); #1;
        end
        S_Valid = 0; M_Ready = 0;
        checks++; if (ni !== 5 || M_Valid !== 1'b1 || S_Ready !== 1'b0) begin errors++; $display("FAIL rmid_full got in=%0d mv=%b sr=%b exp in=5 mv=1 sr=0", ni, M_Valid, S_Ready); end
        rst = 1;
        @(posedge clk); #1;
        checks++; if ({S_Ready, M_Valid, M_Last, Busy, Write_Complete} !== 5'b0) begin errors++; $display("FAIL rmid_flags got %b exp 00000", {S_Ready, M_Valid, M_Last, Busy, Write_Complete}); end
        checks++; if (M_Data !== 128'd0 || Beat_Total !== 32'd0) begin errors++; $display("FAIL rmid_data got d=%0h t=%0d exp 0 0", M_Data, Beat_Total); end
        rst = 0;
        @(posedge clk); #1;
        drive_xfer(2, 2, 1, 0, 0, -1, 128'h300);
        checks++; if (n_out !== 4 || n_bad !== 0) begin errors++; $display("FAIL rmid_after got n=%0d bad=%0d exp 4 0", n_out, n_bad); end
        checks++; if (n_wc !== 1 || n_last !== 1) begin errors++; $display("FAIL rmid_after_wc got wc=%0d last=%0d exp 1 1", n_wc, n_last); end
    endtask

    task automatic test_last_stall;
        drive_xfer(3, 1, 1, 2, 0, -1, 128'h400);
        checks++; if (hold_cnt !== 10) begin errors++; $display("FAIL stall_hold got %0d exp 10", hold_cnt); end
        checks++; if (n_unstable !== 0) begin errors++; $display("FAIL stall_stable got %0d exp 0", n_unstable); end
        checks++; if (n_out !== 3 || n_bad !== 0) begin errors++; $display("FAIL stall_data got n=%0d bad=%0d exp 3 0", n_out, n_bad); end
        checks++; if (n_wc !== 1 || wc_iter - last_iter !== 1) begin errors++; $display("FAIL stall_wc got n=%0d delay=%0d exp 1 1", n_wc, wc_iter - last_iter); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_random_676;
        test_zero;
        test_restart;
        test_reset_mid;
        test_last_stall;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reshape_out_framer.md
# reshape_out_framer

Downstream neighbour of the reshape stage: sits between the reshape merged output stream and the DMA S2MM write channel. Per layer it computes the exact beat count from the output feature-map geometry. It passes the stream through a 2-entry registered buffer, drives `M_Last` on the final beat and pulses `Write_Complete` once that beat has left. This gives the DMA a correctly framed transfer and gives the controller a layer-done event independent of the DMA interrupt path.

## Interface

Parameters:
- `DATA_WIDTH`, 128: stream width (equals `AXI_WIDTH_DATA_IN`).
- `WIDTH_FEATURE_SIZE`, 11: width of row/column size registers.
- `WIDTH_CHANNEL_NUM_REG`, 10: width of channel-group count register.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `Start` input 1: one-cycle pulse; latches geometry and arms a transfer.
- `Row_Num_Out_REG` input `WIDTH_FEATURE_SIZE`: output rows.
- `Col_Num_Out_REG` input `WIDTH_FEATURE_SIZE`: output columns.
- `Channel_Out_Num_REG` input `WIDTH_CHANNEL_NUM_REG`: channel groups; one beat per group per pixel.
- `S_Data` input `DATA_WIDTH`: upstream data from the reshape output.
- `S_Valid` input 1: upstream valid.
- `S_Ready` output 1: upstream ready.
- `M_Data` output `DATA_WIDTH`: data to DMA.
- `M_Valid` output 1: valid to DMA.
- `M_Ready` input 1: DMA ready.
- `M_Last` output 1: asserted with the final beat of the transfer.
- `Busy` output 1: high from `Start` acceptance until `Write_Complete`.
- `Write_Complete` output 1: one-cycle pulse after the last beat is accepted by the DMA.
- `Beat_Total` output 32: latched total beat count, for debug and status.

## Operation

- States: IDLE, CALC1, CALC2, RUN, DONE.
- IDLE:
  - `Start`=1 latches the three geometry inputs, clears both counters, goes to CALC1.
  - `Start` in any other state is ignored.
- CALC1: `prod_rc <= rows*cols` (22 bits, unsigned).
- CALC2: `Beat_Total <= prod_rc*groups`, zero-extended to 32 bits with no overflow possible (max 22+10 bits).
  - Product 0 goes to DONE directly: no beats, no `M_Last`, `Write_Complete` still pulses.
  - Otherwise goes to RUN.
- RUN:
  - `in_cnt` counts S handshakes (`S_Valid & S_Ready`).
  - `out_cnt` counts M handshakes (`M_Valid & M_Ready`).
  - `S_Ready = (state==RUN) & (in_cnt < Beat_Total) & (fifo_cnt < 2)`.
  - Beats beyond `Beat_Total` are never accepted; they are left pending upstream.
- Buffer: 2-entry FIFO, data order preserved.
  - `M_Valid = fifo_cnt != 0`.
  - `M_Data` = head entry.
  - Simultaneous push and pop with `fifo_cnt==2` is not possible because `S_Ready`=0. At `fifo_cnt==1`, push+pop keeps the count at 1.
- `M_Last = M_Valid & (out_cnt == Beat_Total-1)`; it is held stable while `M_Ready`=0.
- When the handshake with `M_Last`=1 completes, go to DONE.
- DONE: `Write_Complete`=1 for exactly this cycle, `Busy`=0, next state IDLE. `Beat_Total` keeps its value until the next `Start`.
- Reset mid-transfer: on any cycle with `rst`=1, the next state is IDLE, counters and FIFO are cleared, and partial data is discarded. No `M_Last` or `Write_Complete` is generated.

## Timing

- Reset values:
  - `S_Ready`=0, `M_Valid`=0, `M_Last`=0, `Busy`=0, `Write_Complete`=0, `Beat_Total`=0.
  - `M_Data`=0, state IDLE.
- `Start` at cycle T: `Busy`=1 at T+1 (CALC1), RUN at T+3. The earliest `S_Ready`=1 is T+3.
- Pass-through latency: a beat accepted on S at cycle N is presented on M at N+1.
- Throughput: 1 beat/cycle sustained while `M_Ready`=1.
- AXI-Stream rules:
  - Once `M_Valid`=1, `M_Data`, `M_Valid` and `M_Last` hold until `M_Ready`.
  - `S_Ready` may drop without a handshake.
- Last beat accepted at cycle L: DONE (and `Write_Complete`=1) at L+1, IDLE at L+2. A new `Start` is accepted at L+2 at the earliest.
- Zero-size transfer: `Start` at T gives `Write_Complete` at T+3.

## Test plan

- Geometry 2x2x1, `M_Ready`=1, continuous `S_Valid`, data 1..4: M outputs 1,2,3,4 with `M_Last` only on 4. `Write_Complete` pulses 1 cycle after beat 4; `Beat_Total`=4.
- 13x13x4 (676 beats) with random `M_Ready` (50%) and random `S_Valid`: M data equals S data in order, exactly 676 M beats, one `M_Last`. `S_Ready`=0 after beat 676 while upstream keeps `S_Valid`=1.
- Columns=0 (5x0x3): no M beats, `S_Ready` never high, `Write_Complete` at `Start`+3.
- Second `Start` pulsed mid-RUN of a 3x3x2 transfer: ignored; transfer completes with 18 beats and one `Write_Complete`.
- `rst` asserted after 5 of 16 beats with the FIFO full: next cycle all outputs are at reset values. A following 2x2x1 transfer completes cleanly with 4 beats.
- `M_Ready`=0 while `M_Last` is presented for 10 cycles: `M_Data` and `M_Last` stay stable, and `Write_Complete` pulses 1 cycle after `M_Ready` rises.
